// File: rtl/edge_store_arb_pkg.sv
// Shared constants, access-type encoding and range helper for the edge-weight store.
package edge_store_arb_pkg;

    localparam int          DEFAULT_MAX_NODES    = 6;
    localparam int          DEFAULT_INDEX_WIDTH  = 3;
    localparam int          DEFAULT_VALUE_WIDTH  = 32;
    localparam int          DEFAULT_NUM_RD_PORTS = 2;
    localparam logic [31:0] EDGE_INF_VALUE       = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_SWEEP,
        ACC_WRITE,
        ACC_READ
    } ram_access_t;

    function automatic logic node_pair_in_range(int from_idx, int to_idx, int max_nodes);
        return (from_idx < max_nodes) && (to_idx < max_nodes);
    endfunction

endpackage

// File: rtl/edge_store_arb_rr.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer moves to the channel after the winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic          taken;

    always_comb begin
        grant = '0;
        taken = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (enable && !taken && req[i] && (i == (int'(ptr) + k) % N)) begin
                    grant[i] = 1'b1;
                    taken    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) ptr <= PW'((i + 1) % N);
            end
        end
    end

endmodule

// File: rtl/edge_store_arb.sv
// Edge-weight store: one loader write port and NUM_RD_PORTS read channels share a single-port RAM.
// Define EDGE_STORE_CLEAR_EN to build the INF clear sweep; otherwise clear_start is ignored and busy=0.
module edge_store_arb
    import edge_store_arb_pkg::*;
#(
    parameter int MAX_NODES    = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH  = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH  = DEFAULT_VALUE_WIDTH,
    parameter int NUM_RD_PORTS = DEFAULT_NUM_RD_PORTS,
    parameter int READ_LATENCY = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [INDEX_WIDTH-1:0]              wr_from,
    input  logic [INDEX_WIDTH-1:0]              wr_to,
    input  logic [VALUE_WIDTH-1:0]              wr_data,
    input  logic [NUM_RD_PORTS-1:0]             rd_req,
    input  logic [NUM_RD_PORTS*INDEX_WIDTH-1:0] rd_from,
    input  logic [NUM_RD_PORTS*INDEX_WIDTH-1:0] rd_to,
    output logic [NUM_RD_PORTS-1:0]             rd_grant,
    output logic [NUM_RD_PORTS-1:0]             rd_valid,
    output logic [NUM_RD_PORTS*VALUE_WIDTH-1:0] rd_data,
    input  logic                                clear_start,
    output logic                                busy
);
    localparam int AW    = 2 * INDEX_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [VALUE_WIDTH-1:0] INF_VAL = VALUE_WIDTH'(EDGE_INF_VALUE);

    logic [VALUE_WIDTH-1:0]  mem [DEPTH];
    logic                    ready_q;
    logic                    wr_fire;
    logic                    sweep_we;
    logic [AW-1:0]           sweep_addr;
    ram_access_t             access;
    logic [INDEX_WIDTH-1:0]  sel_from;
    logic [INDEX_WIDTH-1:0]  sel_to;
    logic [VALUE_WIDTH-1:0]  rd_value;
    logic [NUM_RD_PORTS-1:0] out_grant;
    logic [VALUE_WIDTH-1:0]  out_value;

`ifdef EDGE_STORE_CLEAR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            sweep_addr <= '0;
        end else if (busy) begin
            sweep_addr <= sweep_addr + AW'(1);
            if (sweep_addr == AW'(DEPTH - 1)) busy <= 1'b0;
        end else if (clear_start) begin
            busy       <= 1'b1;
            sweep_addr <= '0;
        end
    end
    assign sweep_we = busy;
`else
    logic unused_clear_start;
    assign unused_clear_start = clear_start;
    assign busy       = 1'b0;
    assign sweep_addr = '0;
    assign sweep_we   = 1'b0;
`endif

    // ready_q keeps the write port and arbiter closed until the first edge after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    assign wr_ready = ready_q & ~busy;
    assign wr_fire  = wr_valid & wr_ready;

    always_comb begin
        access = ACC_IDLE;
        if (sweep_we)                 access = ACC_SWEEP;
        else if (wr_fire)             access = ACC_WRITE;
        else if (ready_q && |rd_req)  access = ACC_READ;
    end

    rr_arbiter #(.N(NUM_RD_PORTS)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (rd_req),
        .enable  (access == ACC_READ),
        .grant   (rd_grant)
    );

    always_comb begin
        sel_from = '0;
        sel_to   = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            if (rd_grant[i]) begin
                sel_from = rd_from[i*INDEX_WIDTH +: INDEX_WIDTH];
                sel_to   = rd_to[i*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

    assign rd_value = node_pair_in_range(int'(sel_from), int'(sel_to), MAX_NODES)
                    ? mem[{sel_to, sel_from}] : INF_VAL;

    // Out-of-range writes still occupy the port this cycle but leave the RAM untouched
    always_ff @(posedge clock) begin
        if (access == ACC_SWEEP) begin
            mem[sweep_addr] <= INF_VAL;
        end else if (access == ACC_WRITE &&
                     node_pair_in_range(int'(wr_from), int'(wr_to), MAX_NODES)) begin
            mem[{wr_to, wr_from}] <= wr_data;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [NUM_RD_PORTS-1:0] pipe_grant;
            logic [VALUE_WIDTH-1:0]  pipe_value;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_grant <= '0;
                    pipe_value <= '0;
                end else begin
                    pipe_grant <= rd_grant;
                    pipe_value <= rd_value;
                end
            end
            assign out_grant = pipe_grant;
            assign out_value = pipe_value;
        end else begin : g_lat1
            assign out_grant = rd_grant;
            assign out_value = rd_value;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= out_grant;
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                if (out_grant[i]) rd_data[i*VALUE_WIDTH +: VALUE_WIDTH] <= out_value;
            end
        end
    end

endmodule

// File: tb/tb_edge_store_arb.sv
// Bench for edge_store_arb: per-cycle comparison against a behavioural store/arbiter model
// plus directed scenarios with literal expectations.
module tb_edge_store_arb;
    localparam int IW  = 3;
    localparam int MN  = 6;
    localparam int NP  = 2;
    localparam int VW  = 32;
    localparam int LAT = 1;
    localparam logic [31:0] INF = 32'h7F80_0000;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [IW-1:0]     wr_from = '0;
    logic [IW-1:0]     wr_to = '0;
    logic [VW-1:0]     wr_data = '0;
    logic [NP-1:0]     rd_req = '0;
    logic [NP*IW-1:0]  rd_from = '0;
    logic [NP*IW-1:0]  rd_to = '0;
    logic [NP-1:0]     rd_grant;
    logic [NP-1:0]     rd_valid;
    logic [NP*VW-1:0]  rd_data;
    logic              clear_start = 1'b0;
    logic              busy;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    edge_store_arb #(
        .MAX_NODES(MN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
        .NUM_RD_PORTS(NP), .READ_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_from(wr_from), .wr_to(wr_to), .wr_data(wr_data),
        .rd_req(rd_req), .rd_from(rd_from), .rd_to(rd_to),
        .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
        .clear_start(clear_start), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    // Behavioural model: contents by (from,to), rotating priority, one-cycle read delay
    logic [VW-1:0]    mem_m [64];
    int               ptr_m = 0;
    bit               ready_m = 1'b0;
    bit               busy_m = 1'b0;
    int               cnt_m = 0;
    logic [NP-1:0]    exp_valid = '0;
    logic [NP*VW-1:0] exp_data = '0;

    always @(negedge clock) begin
        logic [NP-1:0] g;
        bit            fire;
        int            c, f, t;
        if (!reset_n) begin
            check("rst_wr_ready", 64'(wr_ready), 64'd0);
            check("rst_rd_grant", 64'(rd_grant), 64'd0);
            check("rst_rd_valid", 64'(rd_valid), 64'd0);
            check("rst_rd_data",  64'(rd_data),  64'd0);
            check("rst_busy",     64'(busy),     64'd0);
            ready_m   = 1'b0;
            busy_m    = 1'b0;
            ptr_m     = 0;
            exp_valid = '0;
            exp_data  = '0;
        end else begin
            fire = wr_valid && ready_m && !busy_m;
            g = '0;
            if (ready_m && !busy_m && !fire) begin
                for (int k = 0; k < NP; k++) begin
                    c = (ptr_m + k) % NP;
                    if (rd_req[c] && g == '0) g[c] = 1'b1;
                end
            end
            check("wr_ready", 64'(wr_ready), 64'(ready_m && !busy_m));
            check("busy",     64'(busy),     64'(busy_m));
            check("rd_grant", 64'(rd_grant), 64'(g));
            check("rd_valid", 64'(rd_valid), 64'(exp_valid));
            check("rd_data",  64'(rd_data),  64'(exp_data));
            if (busy_m) begin
                mem_m[cnt_m] = INF;
                cnt_m++;
                if (cnt_m == 64) busy_m = 1'b0;
            end else begin
                if (fire && int'(wr_from) < MN && int'(wr_to) < MN)
                    mem_m[int'(wr_to) * 8 + int'(wr_from)] = wr_data;
`ifdef EDGE_STORE_CLEAR_EN
                if (clear_start) begin
                    busy_m = 1'b1;
                    cnt_m  = 0;
                end
`endif
            end
            exp_valid = g;
            for (int k = 0; k < NP; k++) begin
                if (g[k]) begin
                    f = int'(rd_from[k*IW +: IW]);
                    t = int'(rd_to[k*IW +: IW]);
                    exp_data[k*VW +: VW] = (f < MN && t < MN) ? mem_m[t * 8 + f] : INF;
                    ptr_m = (k + 1) % NP;
                end
            end
            ready_m = 1'b1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input int f, input int t, input logic [VW-1:0] d);
        bit ok;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_from  = IW'(f);
        wr_to    = IW'(t);
        wr_data  = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            ok = wr_ready;
            step();
            if (ok) break;
        end
        wr_valid = 1'b0;
        if (!ok) timeout("write_accept");
    endtask

    task automatic do_read(input int ch, input int f, input int t,
                           output logic [VW-1:0] d, output int lat);
        bit g, got;
        g = 1'b0;
        got = 1'b0;
        d = '0;
        lat = 0;
        rd_req[ch] = 1'b1;
        rd_from[ch*IW +: IW] = IW'(f);
        rd_to[ch*IW +: IW]   = IW'(t);
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            g = rd_grant[ch];
            step();
            if (g) break;
        end
        rd_req[ch] = 1'b0;
        if (!g) begin
            timeout("read_grant");
        end else begin
            for (int n = 1; n <= 5; n++) begin
                @(negedge clock);
                if (rd_valid[ch]) begin
                    d = rd_data[ch*VW +: VW];
                    lat = n;
                    got = 1'b1;
                    break;
                end
            end
            step();
            if (!got) timeout("read_valid");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] d;
        int            lat;
        int            n;
        logic [NP-1:0] gseen [4];

        rd_req = 2'b11;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_grant_held_off", 64'(rd_grant), 64'd0);
        check("reset_wr_ready",       64'(wr_ready), 64'd0);
        rd_req = '0;
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("wr_ready_before_edge", 64'(wr_ready), 64'd0);
        @(negedge clock);
        check("wr_ready_after_edge",  64'(wr_ready), 64'd1);
        step();

        for (int f = 0; f < 8; f++)
            for (int t = 0; t < 8; t++)
                do_write(f, t, 32'h1000_0000 | 32'(t * 8 + f));

        do_write(2, 3, 32'h3F80_0000);
        do_read(0, 2, 3, d, lat);
        check("read_2_3_data", 64'(d), 64'h3F80_0000);
        check("read_latency",  64'(lat), 64'(LAT));
        do_read(1, 4, 5, d, lat);
        check("read_4_5_data", 64'(d), 64'h1000_002C);

        rd_from = {IW'(1), IW'(0)};
        rd_to   = {IW'(1), IW'(0)};
        rd_req  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            gseen[i] = rd_grant;
            step();
        end
        rd_req = '0;
        check("alt_grant0", 64'(gseen[0]), 64'b01);
        check("alt_grant1", 64'(gseen[1]), 64'b10);
        check("alt_grant2", 64'(gseen[2]), 64'b01);
        check("alt_grant3", 64'(gseen[3]), 64'b10);

        wr_valid = 1'b1;
        wr_from  = IW'(5);
        wr_to    = IW'(5);
        wr_data  = 32'h4040_0000;
        rd_req   = 2'b11;
        @(negedge clock);
        check("wr_wins_grant",    64'(rd_grant), 64'd0);
        check("wr_wins_wr_ready", 64'(wr_ready), 64'd1);
        step();
        wr_valid = 1'b0;
        @(negedge clock);
        check("read_after_wr_ch0", 64'(rd_grant), 64'b01);
        step();
        rd_req[0] = 1'b0;
        @(negedge clock);
        check("read_after_wr_ch1", 64'(rd_grant), 64'b10);
        step();
        rd_req = '0;
        do_read(0, 5, 5, d, lat);
        check("read_new_5_5", 64'(d), 64'h4040_0000);

        do_read(0, 7, 1, d, lat);
        check("oor_read_7_1", 64'(d), 64'h7F80_0000);
        do_write(1, 6, 32'hDEAD_BEEF);
        do_read(1, 1, 6, d, lat);
        check("oor_read_1_6", 64'(d), 64'h7F80_0000);
        do_read(0, 1, 5, d, lat);
        check("oor_wr_keeps_1_5", 64'(d), 64'h1000_0029);
        do_read(1, 2, 3, d, lat);
        check("oor_wr_keeps_2_3", 64'(d), 64'h3F80_0000);

        rd_from[IW-1:0] = IW'(0);
        rd_to[IW-1:0]   = IW'(3);
        rd_req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("b2b_grant", 64'(rd_grant), 64'b01);
            step();
        end
        rd_req = '0;
        step();

`ifdef EDGE_STORE_CLEAR_EN
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (i == 0) check("sweep_wr_ready", 64'(wr_ready), 64'd0);
            if (!busy) break;
            n++;
        end
        step();
        check("sweep_cycles", 64'(n), 64'd64);
        do_read(0, 2, 3, d, lat);
        check("swept_2_3", 64'(d), 64'h7F80_0000);
        do_read(1, 5, 5, d, lat);
        check("swept_5_5", 64'(d), 64'h7F80_0000);
        do_read(0, 0, 0, d, lat);
        check("swept_0_0", 64'(d), 64'h7F80_0000);

        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (10) step();
        check("sweep_running", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("reset_aborts_busy",  64'(busy),     64'd0);
        check("reset_mid_wr_ready", 64'(wr_ready), 64'd0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (2) step();
        @(negedge clock);
        check("post_abort_busy", 64'(busy), 64'd0);
        step();
`else
        clear_start = 1'b1;
        @(negedge clock);
        check("clear_ignored_busy", 64'(busy), 64'd0);
        step();
        clear_start = 1'b0;
        @(negedge clock);
        check("clear_ignored_busy2",    64'(busy),     64'd0);
        check("clear_ignored_wr_ready", 64'(wr_ready), 64'd1);
        step();
`endif

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
